mmio_bridge: RTL and testbench
==============================

// Module: mmio_bridge
// PURPOSE
//   Parametrised memory-mapped I/O bridge between the pipeline MEM stage and NUM_DEV peripheral channels.
//   Replaces fixed single-cycle IO decode with valid/ready request, per-device ack handshake and wait states.
//   Provides an error response for unmapped windows and (optionally) for timeouts.
//   Drives busy so the pipeline can stall MEM and the earlier stages while an IO access is outstanding.
// PARAMETERS
//   ADDR_W      16      request address width
//   DATA_W      32      data width
//   NUM_DEV     5       peripheral channels (1..16)
//   IO_PAGE     8'hFF   addr[ADDR_W-1:8] value that selects IO space
//   TIMEOUT_CYC 15      WAIT cycles without ack before an error response (only with MMIO_TIMEOUT_EN)
// PORTS
//   clk         in   1               clock
//   rst         in   1               synchronous, active-high reset
//   req_valid   in   1               CPU request valid; qualified by req_is_io
//   req_is_io   out  1               comb: req_addr[ADDR_W-1:8]==IO_PAGE
//   req_ready   out  1               bridge can accept a request (state IDLE)
//   req_we      in   1               1 = write, 0 = read
//   req_addr    in   ADDR_W          byte address; device index = addr[7:4], word offset = addr[3:2]
//   req_wdata   in   DATA_W          write data
//   resp_valid  out  1               one-cycle response pulse
//   resp_rdata  out  DATA_W          read data (0 for writes and errors)
//   resp_err    out  1               unmapped device or timeout; valid with resp_valid
//   busy        out  1               state != IDLE; pipeline stall request
//   dev_req     out  NUM_DEV         one-hot request to the selected device
//   dev_we      out  1               shared write strobe qualifier
//   dev_addr    out  2               shared word offset
//   dev_wdata   out  DATA_W          shared write data
//   dev_ack     in   NUM_DEV         per-device completion
//   dev_rdata   in   NUM_DEV*DATA_W  per-device read data, device i at [i*DATA_W +: DATA_W]
// BEHAVIOUR
//   Reset: state IDLE; resp_valid, resp_rdata, resp_err, dev_req, dev_we, dev_addr, dev_wdata, busy = 0.
//     req_ready = 1 from the first cycle after reset.
//     An in-flight transaction is discarded; dev_req drops and devices must tolerate this.
//   FSM IDLE -> WAIT | RESP -> IDLE:
//   IDLE: req_ready = 1. Accept when req_valid & req_is_io. Latch we, addr, wdata and idx = addr[7:4].
//     idx <  NUM_DEV -> WAIT.
//     idx >= NUM_DEV -> RESP with err = 1 and rdata = 0.
//     A request with req_is_io = 0 is ignored (memory path).
//   WAIT: dev_req[idx] = 1; dev_we, dev_addr and dev_wdata are held stable.
//     dev_ack[idx] = 1 -> capture rdata = read ? dev_rdata[idx] : 0, err = 0, go to RESP.
//       dev_req drops on the same edge.
//     Acks on other channels are ignored. An ack on a channel with dev_req low is ignored.
//   RESP: resp_valid = 1 for exactly one cycle, then IDLE. Response fields hold until the next response.
//   Latency: accept at edge N, dev_req high in cycle N+1. Ack in cycle N+1 gives resp_valid in cycle N+2.
//     Minimum latency is 2 cycles. Back-to-back throughput is 1 access per 3 cycles.
//   busy = 1 in WAIT and RESP; the pipeline must not present a new request until req_ready.
// CONFIGURATION
//   MMIO_TIMEOUT_EN defined:
//     A counter clears on entry to WAIT and increments each WAIT cycle.
//     At count == TIMEOUT_CYC-1 with no ack: go to RESP with err = 1, rdata = 0, dev_req dropped.
//     Ack in the same cycle as the timeout: the ack wins.
//   Undefined: no counter; WAIT persists until ack.
// STRUCTURE
//   mmio_pkg: FSM state enum (IDLE/WAIT/RESP), IO_PAGE default, window field positions (idx [7:4], off [3:2]).
//   Sub-module mmio_decode (combinational): req_addr -> req_is_io, idx, idx_valid (idx < NUM_DEV).
//   FSM, latches, response regs and timeout counter stay in mmio_bridge.
// TESTING
//   Read dev 1: req addr 16'hFF14, dev_ack[1] in first WAIT cycle, rdata 32'h1234 -> resp_valid at cycle 2, rdata 32'h1234, err 0.
//   Write dev 0: addr 16'hFF08, wdata 32'hA5, ack after 3 wait cycles -> dev_addr 2, dev_we 1, resp rdata 0, busy 5 cycles.
//   Unmapped: NUM_DEV=5, addr 16'hFF60 -> no dev_req, resp_valid next cycle, err 1.
//   Timeout (MMIO_TIMEOUT_EN, TIMEOUT_CYC=15): no ack -> dev_req high 15 cycles, then err 1; ack on cycle 15 -> err 0.
//   Reset in WAIT: rst pulse -> next cycle dev_req 0, busy 0, req_ready 1, no resp_valid.
//   Wrong-channel ack: dev_ack[2] while waiting on dev 3 -> ignored; only dev_ack[3] completes.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared types and window layout for the MMIO bridge.
// No logic; constants and the FSM state type only.
// Used by mmio_decode and mmio_bridge.
package mmio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Upper address byte selecting IO space in the default 16-bit map
    localparam logic [7:0] IO_PAGE_DEF = 8'hFF;

    // Field positions inside the 256-byte IO page
    localparam int IDX_MSB = 7;
    localparam int IDX_LSB = 4;
    localparam int OFF_MSB = 3;
    localparam int OFF_LSB = 2;

endpackage

// File: rtl/mmio_bridge_if.sv
// CPU request/response bus plus the shared device channel bundle.
// Pure wiring, no latency.
// Backpressure is carried by req_ready (CPU side) and dev_ack (device side).
interface mmio_bridge_if #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int NUM_DEV = 5
) ();

    logic                      req_valid;
    logic                      req_is_io;
    logic                      req_ready;
    logic                      req_we;
    logic [ADDR_W-1:0]         req_addr;
    logic [DATA_W-1:0]         req_wdata;

    logic                      resp_valid;
    logic [DATA_W-1:0]         resp_rdata;
    logic                      resp_err;
    logic                      busy;

    logic [NUM_DEV-1:0]        dev_req;
    logic                      dev_we;
    logic [1:0]                dev_addr;
    logic [DATA_W-1:0]         dev_wdata;
    logic [NUM_DEV-1:0]        dev_ack;
    logic [NUM_DEV*DATA_W-1:0] dev_rdata;

    // Bridge side
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, dev_ack, dev_rdata,
        output req_is_io, req_ready, resp_valid, resp_rdata, resp_err, busy,
               dev_req, dev_we, dev_addr, dev_wdata
    );

    // CPU plus devices side
    modport master (
        output req_valid, req_we, req_addr, req_wdata, dev_ack, dev_rdata,
        input  req_is_io, req_ready, resp_valid, resp_rdata, resp_err, busy,
               dev_req, dev_we, dev_addr, dev_wdata
    );

endinterface

// File: rtl/mmio_decode.sv
// Address decode: IO page match and device index / range check.
// Purely combinational, zero latency.
// No backpressure; outputs follow the address directly.
module mmio_decode
    import mmio_pkg::*;
#(
    parameter int                ADDR_W  = 16,
    parameter int                NUM_DEV = 5,
    parameter logic [ADDR_W-9:0] IO_PAGE = IO_PAGE_DEF
) (
    input  logic [ADDR_W-1:IDX_LSB] addr_hi,
    output logic                    is_io,
    output logic [3:0]              idx,
    output logic                    idx_valid
);

    assign is_io     = (addr_hi[ADDR_W-1:8] == IO_PAGE);
    assign idx       = addr_hi[IDX_MSB:IDX_LSB];
    assign idx_valid = (int'(idx) < NUM_DEV);

endmodule

// File: rtl/mmio_bridge.sv
// MMIO bridge: pipeline MEM-stage requests to NUM_DEV acked peripheral channels (macro MMIO_TIMEOUT_EN adds a WAIT timeout).
// Latency: accept edge N, dev_req in N+1, resp_valid earliest N+2; unmapped windows respond in N+1.
// Backpressure: req_ready only in IDLE, busy stalls the pipeline; devices stretch WAIT by withholding dev_ack.
module mmio_bridge
    import mmio_pkg::*;
#(
    parameter int                ADDR_W      = 16,
    parameter int                DATA_W      = 32,
    parameter int                NUM_DEV     = 5,
    parameter logic [ADDR_W-9:0] IO_PAGE     = IO_PAGE_DEF,
    parameter int                TIMEOUT_CYC = 15
) (
    input  logic         clk,
    input  logic         rst,
    mmio_bridge_if.slave bus
);

    if (NUM_DEV < 1 || NUM_DEV > 16 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("mmio_bridge: NUM_DEV must be 1..16 and TIMEOUT_CYC at least 1");
    end

    state_t              state_q, state_d;
    logic                dec_is_io, dec_idx_valid;
    logic [3:0]          dec_idx;
    logic                we_q;
    logic [1:0]          off_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [3:0]          idx_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;
    logic [NUM_DEV-1:0]  req_oh;
    logic [DATA_W-1:0]   rd_sel;
    logic                ack_hit;
    logic                to_hit;
    logic                take, fin, fin_err;
    logic [DATA_W-1:0]   fin_rdata;
    logic                unused_addr_lsb;

    mmio_decode #(
        .ADDR_W  (ADDR_W),
        .NUM_DEV (NUM_DEV),
        .IO_PAGE (IO_PAGE)
    ) u_decode (
        .addr_hi   (bus.req_addr[ADDR_W-1:IDX_LSB]),
        .is_io     (dec_is_io),
        .idx       (dec_idx),
        .idx_valid (dec_idx_valid)
    );

    // Byte lane bits are meaningless for word-wide device registers
    assign unused_addr_lsb = ^bus.req_addr[OFF_LSB-1:0];

    // One-hot request to the latched device and mux of its read data
    always_comb begin
        req_oh = '0;
        rd_sel = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            req_oh[i] = (state_q == ST_WAIT) && (idx_q == 4'(i));
            if (idx_q == 4'(i)) begin
                rd_sel = bus.dev_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Only the ack of the channel currently requested can complete WAIT
    assign ack_hit = |(bus.dev_ack & req_oh);

`ifdef MMIO_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt_q;

    assign to_hit = (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

    // Cycles spent in WAIT; held at zero outside WAIT so every entry starts fresh
    always_ff @(posedge clk) begin
        if (rst || state_q != ST_WAIT) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    // Next state plus the accept and response-capture strobes
    always_comb begin
        state_d   = state_q;
        take      = 1'b0;
        fin       = 1'b0;
        fin_err   = 1'b0;
        fin_rdata = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && dec_is_io) begin
                    take = 1'b1;
                    if (dec_idx_valid) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_RESP;
                        fin     = 1'b1;
                        fin_err = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                // An ack arriving on the timeout cycle still completes normally
                if (ack_hit) begin
                    state_d   = ST_RESP;
                    fin       = 1'b1;
                    fin_rdata = we_q ? '0 : rd_sel;
                end else if (to_hit) begin
                    state_d = ST_RESP;
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request latch on accept and response capture on completion
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            off_q   <= '0;
            wdata_q <= '0;
            idx_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (take) begin
                we_q    <= bus.req_we;
                off_q   <= bus.req_addr[OFF_MSB:OFF_LSB];
                wdata_q <= bus.req_wdata;
                idx_q   <= dec_idx;
            end
            if (fin) begin
                rdata_q <= fin_rdata;
                err_q   <= fin_err;
            end
        end
    end

    assign bus.req_is_io  = dec_is_io;
    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.dev_req    = req_oh;
    assign bus.dev_we     = we_q;
    assign bus.dev_addr   = off_q;
    assign bus.dev_wdata  = wdata_q;

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed bench for mmio_bridge: vector table of single accesses plus hand-written
// sequences for ignored requests/acks, wrong-channel ack, reset in WAIT and timeout.
// Inputs are driven and outputs sampled on the falling edge.
module tb_mmio_bridge;

    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 32;
    localparam int NUM_DEV     = 5;
    localparam int TIMEOUT_CYC = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mmio_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_DEV(NUM_DEV)) bus ();

    mmio_bridge #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .NUM_DEV     (NUM_DEV),
        .IO_PAGE     (8'hFF),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Devices return recognisable junk unless the bench is acking them
    task automatic idle_devices();
        bus.dev_ack = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            bus.dev_rdata[i*DATA_W +: DATA_W] = 32'hDEAD_0000 + 32'(i);
        end
    endtask

    // Present one request for one cycle; returns at the falling edge of cycle N+1
    task automatic start_req(input logic we, input logic [15:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        int          delay;     // WAIT cycles before the ack cycle
        logic [31:0] dev_data;  // what the device drives while acking
        logic [4:0]  exp_req;
        logic [1:0]  exp_off;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;   // accept edge to resp_valid, equals busy cycles
    } vec_t;

    vec_t vecs[7];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int lat, bsy, d, cnt;

        vecs[0] = '{we:1'b0, addr:16'hFF14, wdata:32'h0,         delay:0, dev_data:32'h0000_1234,
                    exp_req:5'b00010, exp_off:2'd1, exp_rdata:32'h0000_1234, exp_err:1'b0, exp_lat:2};
        vecs[1] = '{we:1'b1, addr:16'hFF08, wdata:32'h0000_00A5, delay:3, dev_data:32'hFFFF_FFFF,
                    exp_req:5'b00001, exp_off:2'd2, exp_rdata:32'h0,         exp_err:1'b0, exp_lat:5};
        vecs[2] = '{we:1'b0, addr:16'hFF60, wdata:32'h0,         delay:0, dev_data:32'h0,
                    exp_req:5'b00000, exp_off:2'd0, exp_rdata:32'h0,         exp_err:1'b1, exp_lat:1};
        vecs[3] = '{we:1'b0, addr:16'hFF4C, wdata:32'h0,         delay:1, dev_data:32'hCAFE_BABE,
                    exp_req:5'b10000, exp_off:2'd3, exp_rdata:32'hCAFE_BABE, exp_err:1'b0, exp_lat:3};
        vecs[4] = '{we:1'b1, addr:16'hFFF0, wdata:32'h1111_2222, delay:0, dev_data:32'h0,
                    exp_req:5'b00000, exp_off:2'd0, exp_rdata:32'h0,         exp_err:1'b1, exp_lat:1};
        vecs[5] = '{we:1'b0, addr:16'hFF30, wdata:32'h0,         delay:2, dev_data:32'h0BAD_F00D,
                    exp_req:5'b01000, exp_off:2'd0, exp_rdata:32'h0BAD_F00D, exp_err:1'b0, exp_lat:4};
        vecs[6] = '{we:1'b1, addr:16'hFF24, wdata:32'h5555_AAAA, delay:0, dev_data:32'h7777_7777,
                    exp_req:5'b00100, exp_off:2'd1, exp_rdata:32'h0,         exp_err:1'b0, exp_lat:2};

        // Reset values
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        idle_devices();
        repeat (3) @(negedge clk);
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_resp_rdata", 64'(bus.resp_rdata), 64'd0);
        chk("rst_resp_err",   64'(bus.resp_err),   64'd0);
        chk("rst_dev_req",    64'(bus.dev_req),    64'd0);
        chk("rst_dev_we",     64'(bus.dev_we),     64'd0);
        chk("rst_dev_addr",   64'(bus.dev_addr),   64'd0);
        chk("rst_dev_wdata",  64'(bus.dev_wdata),  64'd0);
        chk("rst_busy",       64'(bus.busy),       64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready",  64'(bus.req_ready),  64'd1);

        // Table of single accesses
        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            chk($sformatf("v%0d_ready", v), 64'(bus.req_ready), 64'd1);
            bus.req_valid = 1'b1;
            bus.req_we    = vecs[v].we;
            bus.req_addr  = vecs[v].addr;
            bus.req_wdata = vecs[v].wdata;
            #1;
            chk($sformatf("v%0d_is_io", v), 64'(bus.req_is_io), 64'd1);
            @(negedge clk);
            bus.req_valid = 1'b0;
            d   = int'(vecs[v].addr[7:4]);
            lat = 0;
            bsy = 0;
            for (int cyc = 1; cyc <= 40; cyc++) begin
                if (cyc > 1) @(negedge clk);
                idle_devices();
                if (bus.busy) bsy++;
                if (bus.resp_valid) begin
                    lat = cyc;
                    break;
                end
                chk($sformatf("v%0d_c%0d_dev_req", v, cyc), 64'(bus.dev_req), 64'(vecs[v].exp_req));
                chk($sformatf("v%0d_c%0d_dev_addr", v, cyc), 64'(bus.dev_addr), 64'(vecs[v].exp_off));
                chk($sformatf("v%0d_c%0d_dev_we", v, cyc), 64'(bus.dev_we), 64'(vecs[v].we));
                if (vecs[v].we)
                    chk($sformatf("v%0d_c%0d_dev_wdata", v, cyc), 64'(bus.dev_wdata), 64'(vecs[v].wdata));
                if (vecs[v].exp_req != 5'b0 && cyc - 1 == vecs[v].delay) begin
                    bus.dev_ack[d] = 1'b1;
                    bus.dev_rdata[d*DATA_W +: DATA_W] = vecs[v].dev_data;
                end
            end
            chk($sformatf("v%0d_latency", v), 64'(lat), 64'(vecs[v].exp_lat));
            chk($sformatf("v%0d_busy_cycles", v), 64'(bsy), 64'(vecs[v].exp_lat));
            chk($sformatf("v%0d_rdata", v), 64'(bus.resp_rdata), 64'(vecs[v].exp_rdata));
            chk($sformatf("v%0d_err", v), 64'(bus.resp_err), 64'(vecs[v].exp_err));
            chk($sformatf("v%0d_resp_dev_req", v), 64'(bus.dev_req), 64'd0);
            @(negedge clk);
            chk($sformatf("v%0d_pulse_end", v), 64'(bus.resp_valid), 64'd0);
            chk($sformatf("v%0d_idle_busy", v), 64'(bus.busy), 64'd0);
            chk($sformatf("v%0d_rdata_hold", v), 64'(bus.resp_rdata), 64'(vecs[v].exp_rdata));
            chk($sformatf("v%0d_err_hold", v), 64'(bus.resp_err), 64'(vecs[v].exp_err));
        end

        // Non-IO request is left to the memory path
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 16'h1014;
        bus.req_wdata = 32'h9999_9999;
        #1;
        chk("mem_is_io", 64'(bus.req_is_io), 64'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("mem_c%0d_busy", c), 64'(bus.busy), 64'd0);
            chk($sformatf("mem_c%0d_dev_req", c), 64'(bus.dev_req), 64'd0);
            chk($sformatf("mem_c%0d_resp", c), 64'(bus.resp_valid), 64'd0);
        end
        bus.req_valid = 1'b0;

        // Acks while idle do nothing
        bus.dev_ack = 5'b11111;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk($sformatf("idle_ack_c%0d_resp", c), 64'(bus.resp_valid), 64'd0);
            chk($sformatf("idle_ack_c%0d_busy", c), 64'(bus.busy), 64'd0);
        end
        idle_devices();

        // Ack on the wrong channel is ignored
        start_req(1'b0, 16'hFF38, 32'h0);
        chk("wc_dev_req", 64'(bus.dev_req), 64'b01000);
        chk("wc_dev_addr", 64'(bus.dev_addr), 64'd2);
        bus.dev_ack[2] = 1'b1;
        bus.dev_rdata[2*DATA_W +: DATA_W] = 32'hBAD0_0002;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("wc_c%0d_resp", c), 64'(bus.resp_valid), 64'd0);
            chk($sformatf("wc_c%0d_busy", c), 64'(bus.busy), 64'd1);
            chk($sformatf("wc_c%0d_dev_req", c), 64'(bus.dev_req), 64'b01000);
        end
        idle_devices();
        bus.dev_ack[3] = 1'b1;
        bus.dev_rdata[3*DATA_W +: DATA_W] = 32'h3333_0003;
        @(negedge clk);
        idle_devices();
        chk("wc_resp_valid", 64'(bus.resp_valid), 64'd1);
        chk("wc_rdata", 64'(bus.resp_rdata), 64'h3333_0003);
        chk("wc_err", 64'(bus.resp_err), 64'd0);
        @(negedge clk);

        // Reset while waiting discards the access
        start_req(1'b1, 16'hFF14, 32'h0000_0077);
        chk("rw_dev_req", 64'(bus.dev_req), 64'b00010);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rw_dev_req_drop", 64'(bus.dev_req), 64'd0);
        chk("rw_busy", 64'(bus.busy), 64'd0);
        chk("rw_ready", 64'(bus.req_ready), 64'd1);
        chk("rw_resp", 64'(bus.resp_valid), 64'd0);
        chk("rw_rdata_cleared", 64'(bus.resp_rdata), 64'd0);
        chk("rw_dev_we_cleared", 64'(bus.dev_we), 64'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rw_c%0d_no_resp", c), 64'(bus.resp_valid), 64'd0);
        end

`ifdef MMIO_TIMEOUT_EN
        // No ack: dev_req held TIMEOUT_CYC cycles, then an error response
        start_req(1'b0, 16'hFF44, 32'h0);
        cnt = 0;
        lat = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (bus.resp_valid) begin
                lat = cyc;
                break;
            end
            if (bus.dev_req == 5'b10000) cnt++;
        end
        chk("to_req_cycles", 64'(cnt), 64'(TIMEOUT_CYC));
        chk("to_latency", 64'(lat), 64'(TIMEOUT_CYC + 1));
        chk("to_err", 64'(bus.resp_err), 64'd1);
        chk("to_rdata", 64'(bus.resp_rdata), 64'd0);
        @(negedge clk);

        // Ack on the final WAIT cycle beats the timeout
        start_req(1'b0, 16'hFF44, 32'h0);
        lat = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (cyc > 1) @(negedge clk);
            idle_devices();
            if (bus.resp_valid) begin
                lat = cyc;
                break;
            end
            if (cyc == TIMEOUT_CYC) begin
                bus.dev_ack[4] = 1'b1;
                bus.dev_rdata[4*DATA_W +: DATA_W] = 32'h4444_0004;
            end
        end
        chk("to_ack_latency", 64'(lat), 64'(TIMEOUT_CYC + 1));
        chk("to_ack_err", 64'(bus.resp_err), 64'd0);
        chk("to_ack_rdata", 64'(bus.resp_rdata), 64'h4444_0004);
        @(negedge clk);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
